bcd_scan_counter: RTL

Four-digit decimal (BCD) up/down counter with a time-multiplexed digit scanner. It sits directly upstream of the `segment7` decoder: each scan slot presents one 4-bit BCD digit on `bcd` for `segment7` to convert to segment drives, plus an active-low digit-enable vector that selects which physical display digit lights. It also provides leading-zero blanking and a wrap/borrow pulse for cascading.

---
 rtl/bcd_scan_counter_if.sv | 24 ++
 rtl/bcd_scan_counter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter_if.sv
// Control and display bus of the BCD scan counter: count controls in, count/scan outputs back.
// The master drives tick/up/clear; the slave (the counter) returns registered count and scan outputs.
interface bcd_scan_counter_if #(
  parameter int DIGITS = 4
);
  logic                  tick;
  logic                  up;
  logic                  clear;
  logic [4*DIGITS-1:0]   count;
  logic [3:0]            bcd;
  logic [DIGITS-1:0]     an;
  logic                  blank;
  logic                  carry;

  modport master (
    output tick, up, clear,
    input  count, bcd, an, blank, carry
  );

  modport slave (
    input  tick, up, clear,
    output count, bcd, an, blank, carry
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with free-running digit scanner and leading-zero blanking.
// count/carry one cycle after tick/clear; scan outputs one cycle after the count/index they show.
module bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_scan_counter_if.slave    bus
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] AN_RST = ~DIGITS'(1);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                carry_q, carry_d;
  logic [DW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [3:0]          bcd_q, bcd_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                blank_q, blank_d;

  logic                ripple;
  logic [3:0]          dig;

  // Digit k (k>0) is a leading zero when it and every more significant digit are zero.
  function automatic logic lead_zero(input logic [4*DIGITS-1:0] c, input int k);
    logic nz;
    nz = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= k && c[4*j +: 4] != 4'd0) nz = 1'b1;
    end
    return (k != 0) && !nz;
  endfunction

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    ripple  = 1'b1;
    dig     = 4'd0;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.tick) begin
      // The step propagates upward only while each digit rolls over.
      for (int k = 0; k < DIGITS; k++) begin
        dig = count_q[4*k +: 4];
        if (ripple) begin
          if (bus.up) begin
            if (dig == 4'd9) begin
              count_d[4*k +: 4] = 4'd0;
            end else begin
              count_d[4*k +: 4] = dig + 4'd1;
              ripple            = 1'b0;
            end
          end else begin
            if (dig == 4'd0) begin
              count_d[4*k +: 4] = 4'd9;
            end else begin
              count_d[4*k +: 4] = dig - 4'd1;
              ripple            = 1'b0;
            end
          end
        end
      end
      carry_d = ripple;
    end
  end

  always_comb begin
    div_d = div_q + DW'(1);
    idx_d = idx_q;
    if (div_q == DW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    bcd_d   = 4'd0;
    an_d    = '1;
    blank_d = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        if (lead_zero(count_q, k)) begin
          blank_d = 1'b1;
        end else begin
          bcd_d   = count_q[4*k +: 4];
          an_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      carry_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      bcd_q   <= 4'd0;
      an_q    <= AN_RST;
      blank_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      bcd_q   <= bcd_d;
      an_q    <= an_d;
      blank_q <= blank_d;
    end
  end

  assign bus.count = count_q;
  assign bus.carry = carry_q;
  assign bus.bcd   = bcd_q;
  assign bus.an    = an_q;
  assign bus.blank = blank_q;

endmodule
